// File: rtl/ce_timebase_pkg.sv
// Shared types and elaboration helpers for the clock-enable timebase.
package ce_timebase_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_e;

    localparam int unsigned HZ_PER_MHZ     = 1000000;
    localparam int unsigned DEFAULT_FCLK   = 50000000;

    function automatic int unsigned calc_div_us(input int unsigned fclk);
        return fclk / HZ_PER_MHZ;
    endfunction

    localparam int unsigned DEFAULT_DIV_US = calc_div_us(DEFAULT_FCLK);

    // Counter width for a 0..n-1 range; never returns 0 so DIV=1 still gets a register.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ce_timebase_if.sv
// Control/status bundle between the timebase and its consumer.
interface ce_timebase_if #(
    parameter int unsigned PW = 16
);
    logic          en;
    logic          sync_clr;
    logic          ce1us;
    logic          ce1ms;
    logic          ce1s;
    logic [PW-1:0] tmr_period;
    logic          tmr_start;
    logic          tmr_stop;
    logic          tmr_mode;
    logic          tmr_busy;
    logic          tmr_tick;
    logic          tmr_err;

    modport master (
        output en, sync_clr, tmr_period, tmr_start, tmr_stop, tmr_mode,
        input  ce1us, ce1ms, ce1s, tmr_busy, tmr_tick, tmr_err
    );

    modport slave (
        input  en, sync_clr, tmr_period, tmr_start, tmr_stop, tmr_mode,
        output ce1us, ce1ms, ce1s, tmr_busy, tmr_tick, tmr_err
    );
endinterface

// File: rtl/ce_timebase_prescaler.sv
// Modulo-DIV up-counter; wrap is combinational so the next tier can advance on the same edge.
module ce_prescaler
    import ce_timebase_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    output logic wrap
);
    localparam int unsigned W    = clog2_min1(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = adv && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ce_timebase.sv
// Cascaded 1us/1ms/1s strobe generator plus a millisecond interval timer.
//   state | meaning
//   IDLE  | timer stopped, busy low
//   RUN   | counting ce1ms strobes down from the loaded period
module ce_timebase
    import ce_timebase_pkg::*;
#(
    parameter int unsigned FCLK      = DEFAULT_FCLK,
    parameter int unsigned US_PER_MS = 1000,
    parameter int unsigned MS_PER_S  = 1000,
    parameter int unsigned PW        = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    ce_timebase_if.slave bus
);
    localparam int unsigned DIV_US = calc_div_us(FCLK);

    if ((FCLK % HZ_PER_MHZ) != 0 || DIV_US == 0) begin : g_bad_fclk
        $error("ce_timebase: FCLK must be a non-zero multiple of 1 MHz");
    end

    logic adv_us;
    logic wrap_us;
    logic wrap_ms;
    logic wrap_s;

    assign adv_us = bus.en && !bus.sync_clr;

    ce_prescaler #(.DIV(DIV_US)) u_pre_us (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (bus.sync_clr),
        .adv  (adv_us),
        .wrap (wrap_us)
    );

    ce_prescaler #(.DIV(US_PER_MS)) u_pre_ms (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (bus.sync_clr),
        .adv  (wrap_us),
        .wrap (wrap_ms)
    );

    ce_prescaler #(.DIV(MS_PER_S)) u_pre_s (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (bus.sync_clr),
        .adv  (wrap_ms),
        .wrap (wrap_s)
    );

    logic ce1us_q;
    logic ce1ms_q;
    logic ce1s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce1us_q <= 1'b0;
            ce1ms_q <= 1'b0;
            ce1s_q  <= 1'b0;
        end else begin
            ce1us_q <= wrap_us;
            ce1ms_q <= wrap_ms;
            ce1s_q  <= wrap_s;
        end
    end

    tmr_state_e    state_q, state_d;
    logic [PW-1:0] rem_q, rem_d;
    logic          busy_q, busy_d;
    logic          tick_q, tick_d;
    logic          err_q, err_d;

    // Priority: stop, then start/retrigger, then the registered ce1ms countdown.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tick_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.tmr_stop) begin
            state_d = IDLE;
        end else if (bus.tmr_start) begin
            if (bus.tmr_period == '0) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                state_d = RUN;
                rem_d   = bus.tmr_period;
            end
        end else if (state_q == RUN && ce1ms_q) begin
            if (rem_q != PW'(1)) begin
                rem_d = rem_q - 1'b1;
            end else begin
                tick_d = 1'b1;
                if (!bus.tmr_mode) begin
                    state_d = IDLE;
                end else begin
                    rem_d = bus.tmr_period;
                    if (bus.tmr_period == '0) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    assign bus.ce1us    = ce1us_q;
    assign bus.ce1ms    = ce1ms_q;
    assign bus.ce1s     = ce1s_q;
    assign bus.tmr_busy = busy_q;
    assign bus.tmr_tick = tick_q;
    assign bus.tmr_err  = err_q;
endmodule

// File: tb/tb_ce_timebase.sv
// Scoreboard bench for ce_timebase with short tiers (2 clk/us, 4 us/ms, 3 ms/s).
module tb_ce_timebase;
    localparam int unsigned FCLK = 2000000;
    localparam int unsigned UPM  = 4;
    localparam int unsigned MPS  = 3;
    localparam int unsigned PW   = 16;
    localparam int DIVU     = 2;
    localparam int MS_EDGES = DIVU * 4;
    localparam int S_EDGES  = MS_EDGES * 3;

    typedef struct packed {
        logic us;
        logic ms;
        logic s;
        logic busy;
        logic tick;
        logic err;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    obs_t exp_q[$];
    obs_t m;
    int   n;
    int   m_rem;

    always #5 clk = ~clk;

    ce_timebase_if #(.PW(PW)) bus ();

    ce_timebase #(
        .FCLK     (FCLK),
        .US_PER_MS(UPM),
        .MS_PER_S (MPS),
        .PW       (PW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic obs_t observe();
        return {bus.ce1us, bus.ce1ms, bus.ce1s, bus.tmr_busy, bus.tmr_tick, bus.tmr_err};
    endfunction

    task automatic drive_idle();
        bus.en         = 1'b1;
        bus.sync_clr   = 1'b0;
        bus.tmr_period = 16'd0;
        bus.tmr_start  = 1'b0;
        bus.tmr_stop   = 1'b0;
        bus.tmr_mode   = 1'b0;
    endtask

    task automatic model_reset();
        n     = 0;
        m     = '0;
        m_rem = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Predict the outputs of the coming edge from the current inputs, queue them, then clock.
    task automatic step();
        obs_t nx;
        nx = '0;
        if (bus.sync_clr) begin
            n = 0;
        end else if (bus.en) begin
            n++;
            nx.us = (n % DIVU == 0);
            nx.ms = (n % MS_EDGES == 0);
            nx.s  = (n % S_EDGES == 0);
        end
        nx.busy = m.busy;
        if (bus.tmr_stop) begin
            nx.busy = 1'b0;
        end else if (bus.tmr_start) begin
            if (bus.tmr_period == 16'd0) begin
                nx.err  = 1'b1;
                nx.busy = 1'b0;
            end else begin
                m_rem   = int'(bus.tmr_period);
                nx.busy = 1'b1;
            end
        end else if (m.busy && m.ms) begin
            if (m_rem != 1) begin
                m_rem--;
            end else begin
                nx.tick = 1'b1;
                if (!bus.tmr_mode) begin
                    nx.busy = 1'b0;
                end else begin
                    m_rem = int'(bus.tmr_period);
                    if (m_rem == 0) begin
                        nx.busy = 1'b0;
                        nx.err  = 1'b1;
                    end
                end
            end
        end
        exp_q.push_back(nx);
        m = nx;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o, ex;
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        o = observe();
        vectors++;
        if (o !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_state got=%b exp=%b", o, 6'b0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int e = 1; e <= 4; e++) begin
            step();
            o  = observe();
            ex = exp_q.pop_front();
            vectors++;
            if (o !== ex) begin
                miscompares++;
                $display("FAIL reset_release e=%0d got=%b exp=%b (us ms s busy tick err)", e, o, ex);
            end
        end
    endtask

    task automatic test_free_run();
        obs_t o, ex;
        int   s_edges[$];
        int   ms_edges[$];
        apply_reset();
        for (int e = 1; e <= 50; e++) begin
            step();
            o  = observe();
            ex = exp_q.pop_front();
            vectors++;
            if (o !== ex) begin
                miscompares++;
                $display("FAIL free_run e=%0d got=%b exp=%b (us ms s busy tick err)", e, o, ex);
            end
            if (o.s) s_edges.push_back(e);
            if (o.ms) ms_edges.push_back(e);
        end
        vectors++;
        if (s_edges.size() != 2 || s_edges[0] != 24 || s_edges[1] != 48) begin
            miscompares++;
            $display("FAIL free_run_ce1s count=%0d first=%0d exp 2 strobes at 24,48",
                     s_edges.size(), (s_edges.size() > 0) ? s_edges[0] : -1);
        end
        vectors++;
        if (ms_edges.size() != 6 || ms_edges[0] != 8) begin
            miscompares++;
            $display("FAIL free_run_ce1ms count=%0d exp 6 first at 8", ms_edges.size());
        end
    endtask

    task automatic test_enable_gap();
        obs_t o, ex;
        int   ms_edges[$];
        apply_reset();
        for (int e = 1; e <= 40; e++) begin
            bus.en = !(e >= 9 && e <= 13);
            step();
            o  = observe();
            ex = exp_q.pop_front();
            vectors++;
            if (o !== ex) begin
                miscompares++;
                $display("FAIL enable_gap e=%0d got=%b exp=%b (us ms s busy tick err)", e, o, ex);
            end
            if (o.ms) ms_edges.push_back(e);
        end
        vectors++;
        if (ms_edges.size() != 4 || ms_edges[1] != 21 || ms_edges[2] != 29) begin
            miscompares++;
            $display("FAIL enable_gap_ms count=%0d second=%0d exp second at 21 then 29",
                     ms_edges.size(), (ms_edges.size() > 1) ? ms_edges[1] : -1);
        end
    endtask

    task automatic test_sync_clr();
        obs_t o, ex;
        int   first_us;
        int   first_ms;
        first_us = -1;
        first_ms = -1;
        apply_reset();
        for (int e = 1; e <= 16; e++) begin
            bus.sync_clr = (e == 5);
            step();
            o  = observe();
            ex = exp_q.pop_front();
            vectors++;
            if (o !== ex) begin
                miscompares++;
                $display("FAIL sync_clr e=%0d got=%b exp=%b (us ms s busy tick err)", e, o, ex);
            end
            if (o.us && e > 5 && first_us < 0) first_us = e;
            if (o.ms && first_ms < 0) first_ms = e;
        end
        vectors++;
        if (first_us != 7 || first_ms != 13) begin
            miscompares++;
            $display("FAIL sync_clr_timing us=%0d ms=%0d exp us=7 ms=13", first_us, first_ms);
        end
    endtask

    task automatic test_oneshot();
        obs_t o, ex;
        int   ticks[$];
        apply_reset();
        bus.tmr_period = 16'd3;
        bus.tmr_mode   = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            bus.tmr_start = (e == 9);
            step();
            o  = observe();
            ex = exp_q.pop_front();
            vectors++;
            if (o !== ex) begin
                miscompares++;
                $display("FAIL oneshot e=%0d got=%b exp=%b (us ms s busy tick err)", e, o, ex);
            end
            if (o.tick) ticks.push_back(e);
        end
        vectors++;
        if (ticks.size() != 1 || ticks[0] != 33) begin
            miscompares++;
            $display("FAIL oneshot_tick count=%0d first=%0d exp one tick at 33",
                     ticks.size(), (ticks.size() > 0) ? ticks[0] : -1);
        end
    endtask

    task automatic test_periodic();
        obs_t o, ex;
        int   ticks[$];
        apply_reset();
        bus.tmr_mode = 1'b1;
        for (int e = 1; e <= 64; e++) begin
            bus.tmr_start  = (e == 1);
            bus.tmr_period = (e <= 20) ? 16'd2 : 16'd1;
            bus.tmr_stop   = (e == 57);
            step();
            o  = observe();
            ex = exp_q.pop_front();
            vectors++;
            if (o !== ex) begin
                miscompares++;
                $display("FAIL periodic e=%0d got=%b exp=%b (us ms s busy tick err)", e, o, ex);
            end
            if (o.tick) ticks.push_back(e);
            if (e == 57) begin
                vectors++;
                if (o.busy !== 1'b0 || o.tick !== 1'b0) begin
                    miscompares++;
                    $display("FAIL periodic_stop busy=%b tick=%b exp 0 0", o.busy, o.tick);
                end
            end
        end
        vectors++;
        if (ticks.size() != 4 || ticks[0] != 17 || ticks[1] != 33 || ticks[2] != 41 || ticks[3] != 49) begin
            miscompares++;
            $display("FAIL periodic_ticks count=%0d exp ticks at 17,33,41,49", ticks.size());
        end
    endtask

    task automatic test_err_and_reset();
        obs_t o, ex;
        int   first_us;
        first_us = -1;
        apply_reset();
        for (int e = 1; e <= 12; e++) begin
            bus.tmr_start  = (e == 3) || (e == 5);
            bus.tmr_period = (e == 3) ? 16'd0 : 16'd5;
            step();
            o  = observe();
            ex = exp_q.pop_front();
            vectors++;
            if (o !== ex) begin
                miscompares++;
                $display("FAIL err e=%0d got=%b exp=%b (us ms s busy tick err)", e, o, ex);
            end
            if (e == 3 || e == 4) begin
                vectors++;
                if (o.err !== (e == 3) || o.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL err_pulse e=%0d err=%b busy=%b exp err=%b busy=0", e, o.err, o.busy, (e == 3));
                end
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        o = observe();
        vectors++;
        if (o !== 6'b0) begin
            miscompares++;
            $display("FAIL async_reset got=%b exp=%b", o, 6'b0);
        end
        @(posedge clk);
        #1;
        drive_idle();
        rst_n = 1'b1;
        model_reset();
        for (int e = 1; e <= 4; e++) begin
            step();
            o  = observe();
            ex = exp_q.pop_front();
            vectors++;
            if (o !== ex) begin
                miscompares++;
                $display("FAIL post_reset e=%0d got=%b exp=%b (us ms s busy tick err)", e, o, ex);
            end
            if (o.us && first_us < 0) first_us = e;
        end
        vectors++;
        if (first_us != 2) begin
            miscompares++;
            $display("FAIL post_reset_us first=%0d exp 2", first_us);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_enable_gap();
        test_sync_clr();
        test_oneshot();
        test_periodic();
        test_err_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ce_timebase.md
Name: ce_timebase

Overview:
- Parametrised clock-enable timebase generating cascaded single-cycle strobes at 1 µs, 1 ms and 1 s from the system clock.
- Includes a programmable millisecond interval timer with one-shot and periodic modes, start/stop, retrigger and error reporting.
- Sits at the top of each design as the shared source of time enables for debouncers, display multiplexers, UART timeouts and similar logic.

Parameters:
- FCLK, 50000000, system clock frequency in Hz. Must be an integer multiple of 1000000; otherwise elaboration fails.
- US_PER_MS, 1000, number of ce1us strobes per ce1ms. Overridable to shorten simulation.
- MS_PER_S, 1000, number of ce1ms strobes per ce1s.
- PW, 16, width of the timer period in ms.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global count enable
- sync_clr  in  1  synchronous clear of all prescalers
- ce1us  out  1  1 µs strobe
- ce1ms  out  1  1 ms strobe
- ce1s  out  1  1 s strobe
- tmr_period  in  PW  timer period in ms, sampled at start and at each periodic reload
- tmr_start  in  1  start or retrigger the timer
- tmr_stop  in  1  stop the timer
- tmr_mode  in  1  0 = one-shot, 1 = periodic
- tmr_busy  out  1  timer running
- tmr_tick  out  1  timer expiry strobe
- tmr_err  out  1  period==0 error strobe

Behaviour:
- One clock domain. rst_n is asynchronous and active-low. While rst_n=0, all outputs and counters are 0 and the timer state is IDLE. All outputs are registered.
- DIV_US = FCLK/1000000.
- µs tier: counter cnt_us over 0..DIV_US-1. On an edge with en=1 and sync_clr=0: if cnt_us==DIV_US-1, then cnt_us<=0 and ce1us<=1; otherwise cnt_us++ and ce1us<=0.
- First ce1us is visible after the DIV_US-th enabled edge following reset release. With DIV_US=1, ce1us stays high continuously while en=1.
- ms tier: cnt_ms advances only on edges where the µs tier wraps. ce1ms<=1 when the µs tier wraps and cnt_ms==US_PER_MS-1. ce1ms is therefore always coincident with a ce1us.
- s tier: built the same way on the ms wrap with MS_PER_S. ce1s is coincident with ce1ms and ce1us.
- en=0: all counters hold; all strobes are 0 on the next edge. No strobe is lost or added; the timing only shifts by the disabled cycles.
- sync_clr=1 (has priority over en): all counters go to 0 and all strobes to 0 on the next edge. Timer state is unaffected.
- Timer FSM, states IDLE and RUN. Register rem is PW bits wide.
  - IDLE + tmr_start + tmr_period!=0: rem<=tmr_period, go to RUN, tmr_busy<=1.
  - tmr_start with tmr_period==0 (in any state): tmr_err pulses for 1 cycle; state goes to or stays IDLE; tmr_busy<=0.
  - RUN + tmr_start: retrigger, reloading rem from tmr_period.
  - RUN + ce1ms (the registered output): if rem!=1, then rem--. If rem==1, tmr_tick<=1, and then:
    - one-shot: go to IDLE, tmr_busy<=0 on the same edge.
    - periodic: rem<=tmr_period. If that value is 0, go to IDLE and pulse tmr_err; tmr_tick still fires.
  - The start cycle never decrements, even if ce1ms is high. Start-to-tick latency is therefore between P-1 ms and P ms, plus 1 clk.
  - tmr_tick always lags the terminal ce1ms by exactly 1 clk.
  - tmr_stop: go to IDLE, tmr_busy<=0 next edge. stop beats start, and stop beats a coincident terminal ce1ms (no tick is produced).
- Reset asserted mid-RUN: immediate IDLE, all outputs 0.

Decomposition:
- Package ce_timebase_pkg holds:
  - timer state enum {IDLE, RUN};
  - localparam computation of DIV_US;
  - width helper function clog2_min1.
- Sub-module ce_prescaler (parameter DIV; inputs clk, rst_n, clr, adv; output wrap) is instantiated three times in cascade, one per tier.
- The top level adds the strobe registers and the timer FSM.

Test Plan:
- Test parameters for all scenarios: FCLK=2000000, US_PER_MS=4, MS_PER_S=3.
1. Free run with en=1 → ce1us after edges 2,4,6…; ce1ms after edges 8,16…; ce1s after edges 24,48. All strobes 1 clk wide and coincident where due.
2. en=0 for edges 9-13 → no strobes during that window; next ce1ms after edge 21 (16+5). Strobe periods are unchanged afterwards.
3. sync_clr at edge 5 → ce1us low after edge 5; next ce1us after edge 7; next ce1ms after edge 13.
4. One-shot, tmr_period=3, start one cycle after a ce1ms → exactly one tmr_tick 1 clk after the 3rd following ce1ms; tmr_busy falls on the same edge; no further ticks.
5. Periodic, P=2 → ticks every 16 clk. Set tmr_period=1 before a reload → ticks every 8 clk afterwards. Assert tmr_stop together with a terminal ce1ms → no tick, tmr_busy=0.
6. tmr_start with tmr_period=0 → tmr_err one cycle, tmr_busy stays 0. Separately, pull rst_n low mid-RUN → all outputs 0 asynchronously; after release, first ce1us after edge 2.
